// File: rtl/fds_ss_pkg.sv
`default_nettype none
// ============================================================================
// Module : fds_ss_pkg
// Brief  : Shared states and byte-map constants for the FDS save-state sequencer
// Rev    : 1.0  initial release
// ============================================================================
package fds_ss_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM_S  = 3'd1,
    ST_ARM_L  = 3'd2,
    ST_S_ADDR = 3'd3,
    ST_S_PUSH = 3'd4,
    ST_L_WAIT = 3'd5,
    ST_L_WR   = 3'd6,
    ST_REL    = 3'd7
  } ss_state_t;

  localparam int SS_BYTES = 99;

  // Each pair is "last address before a hole" / "first address after it".
  localparam logic [7:0] C_HOLE0_LO = 8'd18;
  localparam logic [7:0] C_HOLE0_HI = 8'd20;
  localparam logic [7:0] C_HOLE1_LO = 8'd25;
  localparam logic [7:0] C_HOLE1_HI = 8'd32;
  localparam logic [7:0] C_HOLE2_LO = 8'd117;
  localparam logic [7:0] C_HOLE2_HI = 8'd120;
  localparam logic [7:0] C_SS_END   = 8'd123;

endpackage
`default_nettype wire

// File: rtl/fds_ss_addr_gen.sv
`default_nettype none
// ============================================================================
// Module : fds_ss_addr_gen
// Brief  : Save-state address register that walks the byte map, skipping holes
// Rev    : 1.0  initial release
// ============================================================================
module fds_ss_addr_gen
  import fds_ss_pkg::*;
#(
  parameter logic [7:0] SS_FIRST = 8'd16,
  parameter logic [7:0] SS_LAST  = C_SS_END
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_first,
  input  logic       step,
  output logic [7:0] addr,
  output logic       last
);

  logic [7:0] r_addr;
  logic [7:0] w_next;

  always_comb begin
    w_next = r_addr + 8'd1;
    if (r_addr == C_HOLE0_LO) w_next = C_HOLE0_HI;
    if (r_addr == C_HOLE1_LO) w_next = C_HOLE1_HI;
    if (r_addr == C_HOLE2_LO) w_next = C_HOLE2_HI;
  end

  // Falling-edge register to stay in phase with the audio block.
  always_ff @(negedge clk or posedge rst) begin
    if (rst)
      r_addr <= 8'd0;
    else if (load_first)
      r_addr <= SS_FIRST;
    else if (step)
      r_addr <= w_next;
  end

  assign addr = r_addr;
  assign last = (r_addr == SS_LAST);

endmodule
`default_nettype wire

// File: rtl/fds_ss_seq.sv
`default_nettype none
// ============================================================================
// Module : fds_ss_seq
// Brief  : Save/load sequencer bridging valid/ready streams to the audio block
// Rev    : 1.0  initial release
// ============================================================================
module fds_ss_seq
  import fds_ss_pkg::*;
#(
  parameter logic [7:0] SS_FIRST = 8'd16,
  parameter logic [7:0] SS_LAST  = 8'd123
) (
  input  logic       m2,
  input  logic       rst,
  input  logic       start_save,
  input  logic       start_load,
  input  logic       abort,
  output logic       ss_act,
  output logic       ss_we,
  output logic [7:0] ss_addr,
  output logic [7:0] ss_wdat,
  input  logic [7:0] ss_rdat,
  output logic [7:0] out_dat,
  output logic       out_vld,
  input  logic       out_rdy,
  input  logic [7:0] in_dat,
  input  logic       in_vld,
  output logic       in_rdy,
  output logic       busy,
  output logic       done,
  output logic       aborted,
  output logic [6:0] byte_cnt
);

  ss_state_t  r_state;
  logic       r_ss_act, r_ss_we, r_out_vld, r_done, r_aborted, r_abt;
  logic [7:0] r_ss_wdat, r_out_dat;
  logic [6:0] r_byte_cnt;
  logic       w_last, w_abort, w_load_first, w_step;

  assign w_abort      = abort && (r_state != ST_IDLE) && (r_state != ST_REL);
  assign w_load_first = (r_state == ST_IDLE) && (start_save || start_load);
  assign w_step       = !w_abort && !w_last &&
                        (((r_state == ST_S_PUSH) && out_rdy) || (r_state == ST_L_WR));

  fds_ss_addr_gen #(
    .SS_FIRST (SS_FIRST),
    .SS_LAST  (SS_LAST)
  ) u_addr_gen (
    .clk        (m2),
    .rst        (rst),
    .load_first (w_load_first),
    .step       (w_step),
    .addr       (ss_addr),
    .last       (w_last)
  );

  always_ff @(negedge m2 or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_ss_act   <= 1'b0;
      r_ss_we    <= 1'b0;
      r_ss_wdat  <= 8'd0;
      r_out_dat  <= 8'd0;
      r_out_vld  <= 1'b0;
      r_done     <= 1'b0;
      r_aborted  <= 1'b0;
      r_abt      <= 1'b0;
      r_byte_cnt <= 7'd0;
    end else begin
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      if (w_abort) begin
        // A handshake or write completing on this same edge still counts.
        r_state   <= ST_REL;
        r_out_vld <= 1'b0;
        r_ss_we   <= 1'b0;
        r_abt     <= 1'b1;
        if ((r_state == ST_L_WR) || ((r_state == ST_S_PUSH) && out_rdy))
          r_byte_cnt <= r_byte_cnt + 7'd1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start_save || start_load) begin
              r_state    <= start_save ? ST_ARM_S : ST_ARM_L;
              r_ss_act   <= 1'b1;
              r_byte_cnt <= 7'd0;
              r_abt      <= 1'b0;
            end
          end
          ST_ARM_S: r_state <= ST_S_ADDR;
          ST_ARM_L: r_state <= ST_L_WAIT;
          ST_S_ADDR: begin
            r_out_dat <= ss_rdat;
            r_out_vld <= 1'b1;
            r_state   <= ST_S_PUSH;
          end
          ST_S_PUSH: begin
            if (out_rdy) begin
              r_out_vld  <= 1'b0;
              r_byte_cnt <= r_byte_cnt + 7'd1;
              r_state    <= w_last ? ST_REL : ST_S_ADDR;
            end
          end
          ST_L_WAIT: begin
            if (in_vld) begin
              r_ss_wdat <= in_dat;
              r_ss_we   <= 1'b1;
              r_state   <= ST_L_WR;
            end
          end
          ST_L_WR: begin
            r_ss_we    <= 1'b0;
            r_byte_cnt <= r_byte_cnt + 7'd1;
            r_state    <= w_last ? ST_REL : ST_L_WAIT;
          end
          ST_REL: begin
            r_ss_act  <= 1'b0;
            r_done    <= !r_abt;
            r_aborted <= r_abt;
            r_state   <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign ss_act   = r_ss_act;
  assign ss_we    = r_ss_we;
  assign ss_wdat  = r_ss_wdat;
  assign out_dat  = r_out_dat;
  assign out_vld  = r_out_vld;
  assign in_rdy   = (r_state == ST_L_WAIT);
  assign busy     = (r_state != ST_IDLE);
  assign done     = r_done;
  assign aborted  = r_aborted;
  assign byte_cnt = r_byte_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fds_ss_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_fds_ss_seq
// Brief  : Directed self-checking bench for the FDS save-state sequencer
// Rev    : 1.0  initial release
// ============================================================================
module tb_fds_ss_seq;

  logic       m2, rst, start_save, start_load, abort;
  logic       ss_act, ss_we, out_vld, out_rdy, in_vld, in_rdy, busy, done, aborted;
  logic [7:0] ss_addr, ss_wdat, ss_rdat, out_dat, in_dat;
  logic [6:0] byte_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_addr [0:98];

  fds_ss_seq dut (
    .m2(m2), .rst(rst), .start_save(start_save), .start_load(start_load),
    .abort(abort), .ss_act(ss_act), .ss_we(ss_we), .ss_addr(ss_addr),
    .ss_wdat(ss_wdat), .ss_rdat(ss_rdat), .out_dat(out_dat), .out_vld(out_vld),
    .out_rdy(out_rdy), .in_dat(in_dat), .in_vld(in_vld), .in_rdy(in_rdy),
    .busy(busy), .done(done), .aborted(aborted), .byte_cnt(byte_cnt)
  );

  // Audio block read model.
  assign ss_rdat = ss_addr ^ 8'h5A;

  initial begin
    m2 = 1'b1;
    forever #5 m2 = ~m2;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit is_hole(input logic [7:0] a);
    return (a == 8'd19) || (a >= 8'd26 && a <= 8'd31) || (a == 8'd118) || (a == 8'd119);
  endfunction

  task automatic run_save(input int period, input bit both, input int load_at, input int exp_cyc);
    int idx = 0, done_cyc = 0, we_seen = 0, rdy_seen = 0, act_drop = 0;
    bit prev_stall = 0;
    logic [7:0] prev_dat = 8'd0;
    @(posedge m2);
    start_save = 1'b1; start_load = both; out_rdy = 1'b1;
    @(posedge m2);
    start_save = 1'b0; start_load = 1'b0;
    check("save_arm_act",  32'(ss_act),   1);
    check("save_arm_addr", 32'(ss_addr),  16);
    check("save_arm_cnt",  32'(byte_cnt), 0);
    for (int cyc = 1; cyc <= 2000 && done_cyc == 0; cyc++) begin
      @(posedge m2);
      start_load = (cyc == load_at);
      if (done) done_cyc = cyc;
      else begin
        if (!ss_act) act_drop++;
        if (ss_we) we_seen++;
        if (in_rdy) rdy_seen++;
        if (prev_stall) check("save_hold", 32'(out_dat), 32'(prev_dat));
        out_rdy = ((cyc % period) == 0);
        if (out_vld && out_rdy) begin
          if (idx < 99) begin
            check("save_addr", 32'(ss_addr), 32'(exp_addr[idx]));
            check("save_dat",  32'(out_dat), 32'(exp_addr[idx] ^ 8'h5A));
          end
          idx++;
        end
        prev_stall = out_vld && !out_rdy;
        prev_dat   = out_dat;
      end
    end
    start_load = 1'b0;
    check("save_done_seen", 32'(done_cyc != 0), 1);
    if (exp_cyc != 0) check("save_cycles", done_cyc, exp_cyc);
    check("save_bytes",    idx, 99);
    check("save_byte_cnt", 32'(byte_cnt), 99);
    check("save_no_we",    we_seen, 0);
    check("save_no_inrdy", rdy_seen, 0);
    check("save_act_held", act_drop, 0);
    check("save_act_off",  32'(ss_act), 0);
    check("save_not_busy", 32'(busy), 0);
    check("save_no_abort", 32'(aborted), 0);
    @(posedge m2);
    check("save_done_1cyc", 32'(done), 0);
    check("save_cnt_hold",  32'(byte_cnt), 99);
    out_rdy = 1'b0;
  endtask

  task automatic run_load(input int abort_at, input int exp_n, input bit exp_abt, input int exp_cyc);
    int wcount = 0, end_cyc = 0, abort_cyc = 0, act_drop = 0, vld_seen = 0, holes = 0;
    @(posedge m2);
    start_load = 1'b1; in_vld = 1'b1; in_dat = 8'd0;
    @(posedge m2);
    start_load = 1'b0;
    check("load_arm_act",  32'(ss_act),  1);
    check("load_arm_addr", 32'(ss_addr), 16);
    check("load_arm_rdy",  32'(in_rdy),  0);
    for (int cyc = 1; cyc <= 2000 && end_cyc == 0; cyc++) begin
      @(posedge m2);
      if (abort_cyc != 0 && cyc == abort_cyc + 1) begin
        check("rel_act",     32'(ss_act),  1);
        check("rel_we",      32'(ss_we),   0);
        check("rel_busy",    32'(busy),    1);
        check("rel_no_done", 32'(done),    0);
        abort = 1'b0;
      end
      if (done || aborted) end_cyc = cyc;
      else begin
        if (!ss_act) act_drop++;
        if (out_vld) vld_seen++;
        if (is_hole(ss_addr)) holes++;
        if (ss_we) begin
          if (wcount < 99) begin
            check("load_addr", 32'(ss_addr), 32'(exp_addr[wcount]));
            check("load_wdat", 32'(ss_wdat), wcount);
          end
          wcount++;
          in_dat = 8'(wcount);
        end
        if (in_rdy && wcount == abort_at && abort_cyc == 0) begin
          abort = 1'b1;
          abort_cyc = cyc;
        end
      end
    end
    in_vld = 1'b0;
    abort  = 1'b0;
    check("load_end_seen", 32'(end_cyc != 0), 1);
    check("load_cycles",   end_cyc, exp_cyc);
    check("load_we_count", wcount, exp_n);
    check("load_byte_cnt", 32'(byte_cnt), exp_n);
    check("load_done",     32'(done), 32'(!exp_abt));
    check("load_aborted",  32'(aborted), 32'(exp_abt));
    check("load_act_held", act_drop, 0);
    check("load_no_vld",   vld_seen, 0);
    check("load_no_holes", holes, 0);
    @(posedge m2);
    check("load_pulse_1cyc", 32'(done | aborted), 0);
    check("load_act_off",    32'(ss_act), 0);
  endtask

  initial begin
    int k = 0;
    for (int a = 16;  a <= 18;  a++) begin exp_addr[k] = 8'(a); k++; end
    for (int a = 20;  a <= 25;  a++) begin exp_addr[k] = 8'(a); k++; end
    for (int a = 32;  a <= 117; a++) begin exp_addr[k] = 8'(a); k++; end
    for (int a = 120; a <= 123; a++) begin exp_addr[k] = 8'(a); k++; end

    rst = 1'b1; start_save = 1'b0; start_load = 1'b0; abort = 1'b0;
    out_rdy = 1'b0; in_vld = 1'b0; in_dat = 8'd0;
    repeat (2) @(posedge m2);
    check("rst_act",   32'(ss_act),   0);
    check("rst_we",    32'(ss_we),    0);
    check("rst_addr",  32'(ss_addr),  0);
    check("rst_wdat",  32'(ss_wdat),  0);
    check("rst_odat",  32'(out_dat),  0);
    check("rst_ovld",  32'(out_vld),  0);
    check("rst_inrdy", 32'(in_rdy),   0);
    check("rst_busy",  32'(busy),     0);
    check("rst_done",  32'(done),     0);
    check("rst_abt",   32'(aborted),  0);
    check("rst_cnt",   32'(byte_cnt), 0);
    rst = 1'b0;
    @(posedge m2);
    check("idle_busy", 32'(busy), 0);

    run_save(1, 1'b1, 0, 200);
    run_save(3, 1'b0, 50, 0);
    run_load(999, 99, 1'b0, 200);
    run_load(40, 40, 1'b1, 83);

    // Reset between edges while a byte is being offered.
    @(posedge m2);
    start_save = 1'b1; out_rdy = 1'b1;
    @(posedge m2);
    start_save = 1'b0;
    repeat (20) @(posedge m2);
    for (int i = 0; i < 4 && !out_vld; i++) @(posedge m2);
    check("pre_rst_vld", 32'(out_vld), 1);
    out_rdy = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_act",  32'(ss_act),  0);
    check("async_ovld", 32'(out_vld), 0);
    check("async_busy", 32'(busy),    0);
    @(posedge m2);
    rst = 1'b0;
    run_save(1, 1'b0, 0, 200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fds_ss_seq.md
# fds_ss_seq

Save-state sequencer for the FDS expansion-audio block. It walks the audio block's save-state byte map in a fixed order, driving `ss_act`/`ss_we`/`ss_addr`. On save it streams every state byte out over a valid/ready port; on load it takes bytes from an input valid/ready port and writes them back. It sits between the mapper's save-state engine and the audio block's `ss_ctrl`/`ss_rdat` pins, so that block never needs to know about stream flow control.

## Interface
Parameters:
- `SS_FIRST`, default 16: first state address.
- `SS_LAST`, default 123: last state address.

Ports:
- `m2` in 1: clock. All registers update on the falling edge of `m2`, matching the audio block.
- `rst` in 1: reset. Asynchronous, active-high.
- `start_save` in 1: one-cycle request to dump state.
- `start_load` in 1: one-cycle request to restore state.
- `abort` in 1: terminate the current transfer.
- `ss_act` out 1: freezes the audio block and selects save-state access.
- `ss_we` out 1: save-state write strobe.
- `ss_addr` out 8: save-state byte address.
- `ss_wdat` out 8: byte to write; the upstream mux routes it onto `cpu_dat`.
- `ss_rdat` in 8: byte read back from the audio block (combinational).
- `out_dat` out 8, `out_vld` out 1, `out_rdy` in 1: save stream.
- `in_dat` in 8, `in_vld` in 1, `in_rdy` out 1: load stream.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse on normal completion.
- `aborted` out 1: one-cycle pulse on abort completion.
- `byte_cnt` out 7: bytes completed in the current or last transfer.

## Operation
- Address order, 99 bytes total: 16–18, 20–25, 32–117, 120–123.
- Holes 19, 26–31 and 118–119 are never presented.
- Address stepping: 18→20, 25→32, 117→120; 123 is the last address.
- States and transitions:
  - IDLE: `start_save` → ARM_S; `start_load` → ARM_L. If both arrive in the same cycle, save wins.
  - ARM_S / ARM_L: `ss_act`=1, `ss_addr`=16. Always lasts exactly 1 cycle, then → S_ADDR / L_WAIT.
  - S_ADDR: address stable. At the edge, `out_dat`←`ss_rdat`, `out_vld`←1, → S_PUSH.
  - S_PUSH: hold `out_vld` and `out_dat` until the edge where `out_rdy`=1. At that edge, `out_vld`←0, `byte_cnt`++, step address, → S_ADDR, or → REL if the address was 123.
  - L_WAIT: `in_rdy`=1, combinational from state. On `in_vld`&`in_rdy`: `ss_wdat`←`in_dat`, → L_WR.
  - L_WR: `ss_we`=1 for exactly 1 cycle. `byte_cnt`++, step address, → L_WAIT, or → REL after 123.
  - REL: `ss_act`=1, `ss_we`=0 for 1 cycle, then → IDLE. Pulse `done`, or `aborted` if REL was entered through abort.
- `abort` in any non-IDLE state:
  - Next state is REL.
  - `out_vld` is forced to 0 and no `ss_we` is issued.
  - A partial load leaves the addresses already written with their new values.
- `start_*` while `busy` is ignored.
- `byte_cnt` is cleared on ARM and holds its final value (99 on success) in IDLE.

## Timing
- Reset values: `ss_act` 0, `ss_we` 0, `ss_addr` 0, `ss_wdat` 0, `out_dat` 0, `out_vld` 0, `in_rdy` 0, `busy` 0, `done` 0, `aborted` 0, `byte_cnt` 0, state IDLE.
- Asserting `rst` mid-transfer drops `ss_act` immediately, without waiting for a clock edge. No REL cycle is issued.
- `ss_act` rises 1 cycle before the first access and falls 1 cycle after the last access. It never toggles within a transfer.
- Save throughput: 2 cycles per byte with `out_rdy` tied high. A full save takes ARM + 198 + REL = 200 cycles from the `start_save` edge to `done`.
- Load throughput: 2 cycles per byte with `in_vld` tied high, so 200 cycles total.
- `ss_addr` changes only on the edge that leaves S_PUSH or L_WR. It is stable for the entire S_ADDR cycle, so `ss_rdat` has a full cycle to settle.
- `ss_wdat` is stable for the whole L_WR cycle.
- Stream handshake: a transfer happens when valid & ready are both 1 at a falling edge. `out_dat` must not change while `out_vld`=1 and `out_rdy`=0.

## Structure
- Shared package `fds_ss_pkg` holds:
  - the state enum;
  - `SS_BYTES`=99;
  - the hole boundary constants (18/20, 25/32, 117/120, 123).
- Sub-module `fds_ss_addr_gen`:
  - holds the address register, with load-first and step inputs;
  - outputs `addr` and `last`;
  - contains all hole-skip logic.
- The FSM, stream registers and counter live in the top module.

## Test plan
- Full save, `out_rdy`=1: the 99 addresses appear in the listed order. `out_dat` matches a model `ss_rdat` (equal to the address XOR 0x5A). `done` pulses at cycle 200.
- Save with `out_rdy` toggling 1-of-3: no byte is lost or duplicated, `out_dat` holds while stalled, and `byte_cnt` ends at 99.
- Full load of bytes 0..98: `ss_we` is seen on exactly 99 cycles. Addresses 19, 26–31, 118 and 119 are never driven. Each `ss_wdat` equals its stream index.
- `abort` at byte 40 of a load: no further `ss_we`. REL lasts 1 cycle, `aborted` pulses, `done` stays 0, and `byte_cnt`=40.
- `start_save` and `start_load` in the same cycle → save. A `start_load` during a save has no effect.
- `rst` asserted mid-save, between edges: `ss_act` and `out_vld` go 0 asynchronously. After release, a new save runs to completion.
